// File: rtl/tube_pkg.sv
// tube_pkg: shared constants, event tag encoding and decoder state type for
// the tube-data path. One event is 32 words {time[7:0], tag[7:0]} in order
// 3A0..3A7, 3B0..3B7, 4A0..4A7, 4B0..4B7.
package tube_pkg;

    localparam logic [15:0] FILLER_WORD     = 16'h00FF;
    localparam logic [3:0]  CH3_TAG         = 4'b1100;
    localparam logic [3:0]  CH4_TAG         = 4'b0010;
    localparam int          WORDS_PER_EVENT = 32;

    typedef enum logic {
        IDLE  = 1'b0,
        EVENT = 1'b1
    } state_e;

    // Tag for word index k: chamber nibble, layer bit, then the wire index
    // bit-reversed (the Tube module wires its LSB to the tag MSB).
    function automatic logic [7:0] expected_tag(input logic [4:0] k);
        return {(k[4] ? CH4_TAG : CH3_TAG), k[3], k[0], k[1], k[2]};
    endfunction

endpackage

// File: rtl/tag_decode.sv
// tag_decode: combinational tag decoder, inverse of expected_tag().
//   tag_i      8-bit tag from a FIFO word
//   valid_o    chamber nibble is one of the two known chambers
//   chamber_o  0 = chamber 3, 1 = chamber 4
//   layer_o    0 = A, 1 = B
//   wire_o     wire index 0..7 (un-reversed)
//   index_o    word position 0..31 within an event
module tag_decode
    import tube_pkg::*;
(
    input  logic [7:0] tag_i,
    output logic       valid_o,
    output logic       chamber_o,
    output logic       layer_o,
    output logic [2:0] wire_o,
    output logic [4:0] index_o
);

    assign valid_o   = (tag_i[7:4] == CH3_TAG) || (tag_i[7:4] == CH4_TAG);
    assign chamber_o = (tag_i[7:4] == CH4_TAG);
    assign layer_o   = tag_i[3];
    assign wire_o    = {tag_i[0], tag_i[1], tag_i[2]};
    assign index_o   = {chamber_o, layer_o, wire_o};

endmodule

// File: rtl/event_decoder.sv
// event_decoder: read-side consumer of the tube-data FIFO. Pops words one at
// a time, checks each tag against the expected in-event sequence, and emits
// decoded hits on a valid/ready stream. Resyncs on bad framing and counts
// complete events and framing errors.
//   clk, clr_n           clock, asynchronous active-low reset
//   fifo_dout/empty/valid FIFO read side; fifo_rd_en pops one word
//   hit_*                registered hit payload, valid/ready handshake
//   event_count          complete events emitted (wraps)
//   err_flag/err_count   sticky error / saturating error count, err_clear
//                        clears both synchronously
module event_decoder
    import tube_pkg::*;
#(
    parameter int TIMEOUT = 1024,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic [15:0]      fifo_dout,
    input  logic             fifo_empty,
    input  logic             fifo_valid,
    output logic             fifo_rd_en,
    output logic             hit_valid,
    input  logic             hit_ready,
    output logic             hit_chamber,
    output logic             hit_layer,
    output logic [2:0]       hit_wire,
    output logic [7:0]       hit_time,
    output logic             hit_fired,
    output logic             hit_first,
    output logic             hit_last,
    output logic [CNT_W-1:0] event_count,
    output logic             err_flag,
    output logic [7:0]       err_count,
    input  logic             err_clear
);

    localparam int          TO_W     = $clog2(TIMEOUT + 1);
    localparam logic [4:0]  LAST_IDX = 5'(WORDS_PER_EVENT - 1);

    state_e            state_q, state_d;
    logic [4:0]        idx_q, idx_d;
    logic [TO_W-1:0]   idle_q, idle_d;
    logic              inflight_q;
    logic              run_q;

    logic              hit_valid_q, hit_chamber_q, hit_layer_q;
    logic [2:0]        hit_wire_q;
    logic [7:0]        hit_time_q;
    logic              hit_fired_q, hit_first_q, hit_last_q;
    logic [CNT_W-1:0]  event_count_q;
    logic              err_flag_q;
    logic [7:0]        err_count_q;

    logic              dec_valid, dec_chamber, dec_layer;
    logic [2:0]        dec_wire;
    logic [4:0]        dec_index;

    logic              stall, is_filler, match_idx, match_0;
    logic              load, first, last, err;

    tag_decode u_dec (
        .tag_i     (fifo_dout[7:0]),
        .valid_o   (dec_valid),
        .chamber_o (dec_chamber),
        .layer_o   (dec_layer),
        .wire_o    (dec_wire),
        .index_o   (dec_index)
    );

    assign stall     = hit_valid_q & ~hit_ready;
    // run_q keeps the pop request low during and just after reset so that
    // all outputs read 0 while clr_n is asserted.
    assign fifo_rd_en = run_q & ~fifo_empty & ~inflight_q & ~stall;

    assign is_filler = (fifo_dout == FILLER_WORD);
    assign match_idx = dec_valid & (dec_index == idx_q);
    assign match_0   = dec_valid & (dec_index == 5'd0);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        idle_d  = idle_q;
        load    = 1'b0;
        first   = 1'b0;
        last    = 1'b0;
        err     = 1'b0;
        case (state_q)
            IDLE: begin
                idle_d = '0;
                if (fifo_valid) begin
                    if (match_0) begin
                        load    = 1'b1;
                        first   = 1'b1;
                        idx_d   = 5'd1;
                        state_d = EVENT;
                    end else if (!is_filler) begin
                        err = 1'b1;
                    end
                end
            end
            EVENT: begin
                if (fifo_valid) begin
                    idle_d = '0;
                    if (match_idx) begin
                        load = 1'b1;
                        if (idx_q == LAST_IDX) begin
                            last    = 1'b1;
                            idx_d   = 5'd0;
                            state_d = IDLE;
                        end else begin
                            idx_d = idx_q + 5'd1;
                        end
                    end else if (match_0) begin
                        // A fresh index-0 word mid-event: the old event lost
                        // its tail, so restart on this word.
                        err   = 1'b1;
                        load  = 1'b1;
                        first = 1'b1;
                        idx_d = 5'd1;
                    end else begin
                        err     = 1'b1;
                        idx_d   = 5'd0;
                        state_d = IDLE;
                    end
                end else if (!stall) begin
                    // Frozen while stalled so backpressure cannot abort.
                    if (idle_q == TO_W'(TIMEOUT - 1)) begin
                        err     = 1'b1;
                        idx_d   = 5'd0;
                        idle_d  = '0;
                        state_d = IDLE;
                    end else begin
                        idle_d = idle_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            idle_q        <= '0;
            inflight_q    <= 1'b0;
            run_q         <= 1'b0;
            hit_valid_q   <= 1'b0;
            hit_chamber_q <= 1'b0;
            hit_layer_q   <= 1'b0;
            hit_wire_q    <= '0;
            hit_time_q    <= '0;
            hit_fired_q   <= 1'b0;
            hit_first_q   <= 1'b0;
            hit_last_q    <= 1'b0;
            event_count_q <= '0;
            err_flag_q    <= 1'b0;
            err_count_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            idle_q  <= idle_d;
            run_q   <= 1'b1;

            if (fifo_rd_en)      inflight_q <= 1'b1;
            else if (fifo_valid) inflight_q <= 1'b0;

            if (load) begin
                hit_valid_q   <= 1'b1;
                hit_chamber_q <= dec_chamber;
                hit_layer_q   <= dec_layer;
                hit_wire_q    <= dec_wire;
                hit_time_q    <= fifo_dout[15:8];
                hit_fired_q   <= |fifo_dout[15:8];
                hit_first_q   <= first;
                hit_last_q    <= last;
            end else if (hit_ready) begin
                hit_valid_q <= 1'b0;
            end

            if (load && last) event_count_q <= event_count_q + 1'b1;

            if (err_clear) begin
                err_flag_q  <= 1'b0;
                err_count_q <= '0;
            end else if (err) begin
                err_flag_q <= 1'b1;
                if (err_count_q != 8'hFF) err_count_q <= err_count_q + 8'd1;
            end
        end
    end

    assign hit_valid   = hit_valid_q;
    assign hit_chamber = hit_chamber_q;
    assign hit_layer   = hit_layer_q;
    assign hit_wire    = hit_wire_q;
    assign hit_time    = hit_time_q;
    assign hit_fired   = hit_fired_q;
    assign hit_first   = hit_first_q;
    assign hit_last    = hit_last_q;
    assign event_count = event_count_q;
    assign err_flag    = err_flag_q;
    assign err_count   = err_count_q;

endmodule

// File: tb/tb_event_decoder.sv
// Testbench for event_decoder: behavioural FIFO model feeding the DUT and a
// scoreboard of expected hits compared as hits are handed downstream.
module tb_event_decoder;

    localparam int TO = 32;

    logic        clk = 1'b0;
    logic        clr_n = 1'b0;
    logic [15:0] fifo_dout = '0;
    logic        fifo_empty;
    logic        fifo_valid = 1'b0;
    logic        fifo_rd_en;
    logic        hit_valid;
    logic        hit_ready = 1'b1;
    logic        hit_chamber, hit_layer;
    logic [2:0]  hit_wire;
    logic [7:0]  hit_time;
    logic        hit_fired, hit_first, hit_last;
    logic [15:0] event_count;
    logic        err_flag;
    logic [7:0]  err_count;
    logic        err_clear = 1'b0;

    event_decoder #(.TIMEOUT(TO), .CNT_W(16)) dut (
        .clk(clk), .clr_n(clr_n),
        .fifo_dout(fifo_dout), .fifo_empty(fifo_empty), .fifo_valid(fifo_valid),
        .fifo_rd_en(fifo_rd_en),
        .hit_valid(hit_valid), .hit_ready(hit_ready),
        .hit_chamber(hit_chamber), .hit_layer(hit_layer), .hit_wire(hit_wire),
        .hit_time(hit_time), .hit_fired(hit_fired), .hit_first(hit_first),
        .hit_last(hit_last), .event_count(event_count),
        .err_flag(err_flag), .err_count(err_count), .err_clear(err_clear)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int nhits = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- FIFO model ----------------
    logic [15:0] mem [0:1023];
    int wr_ptr = 0;
    int rd_ptr = 0;
    assign fifo_empty = (rd_ptr == wr_ptr);

    always @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            fifo_valid <= 1'b0;
            rd_ptr     <= wr_ptr;
        end else begin
            fifo_valid <= 1'b0;
            if (fifo_rd_en && !fifo_empty) begin
                fifo_dout  <= mem[rd_ptr % 1024];
                fifo_valid <= 1'b1;
                rd_ptr     <= rd_ptr + 1;
            end
        end
    end

    // ---------------- stimulus / expectation helpers ----------------
    logic [15:0] exp_q [$];

    function automatic logic [7:0] tb_tag(input int k);
        logic [4:0] kk;
        logic [3:0] nib;
        kk  = 5'(k);
        nib = kk[4] ? 4'h2 : 4'hC;
        return {nib, kk[3], kk[0], kk[1], kk[2]};
    endfunction

    function automatic logic [15:0] enc(input int k, input int t, input bit f, input bit l);
        logic [4:0] kk;
        logic [7:0] tt;
        kk = 5'(k);
        tt = 8'(t);
        return {kk[4], kk[3], kk[2:0], tt, (tt != 8'd0), f, l};
    endfunction

    task automatic push_raw(input logic [15:0] w);
        mem[wr_ptr % 1024] = w;
        wr_ptr++;
    endtask

    task automatic push_word(input int k, input int t);
        push_raw({8'(t), tb_tag(k)});
    endtask

    task automatic push_hit(input int k, input int t, input bit f, input bit l);
        exp_q.push_back(enc(k, t, f, l));
    endtask

    task automatic push_event(input int t0);
        for (int k = 0; k < 32; k++) begin
            push_word(k, t0 + k);
            push_hit(k, t0 + k, k == 0, k == 31);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (!(exp_q.size() == 0 && fifo_empty && !fifo_valid && !hit_valid) && n < budget) begin
            cyc(1);
            n++;
        end
        chk("drain", 32'(n < budget), 1);
        cyc(4);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_valid"}, hit_valid, 0);
        chk({tag, "_rd_en"}, fifo_rd_en, 0);
        chk({tag, "_evcnt"}, event_count, 0);
        chk({tag, "_eflag"}, err_flag, 0);
        chk({tag, "_ecnt"}, err_count, 0);
        chk({tag, "_payload"}, {hit_chamber, hit_layer, hit_wire, hit_time, hit_fired, hit_first, hit_last}, 0);
    endtask

    task automatic do_reset();
        clr_n = 1'b0;
        hit_ready = 1'b1;
        err_clear = 1'b0;
        #1;
        exp_q.delete();
        cyc(2);
        clr_n = 1'b1;
        cyc(1);
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (clr_n && hit_valid && hit_ready) begin
            nhits++;
            if (exp_q.size() == 0) begin
                chk("spurious_hit", {hit_chamber, hit_layer, hit_wire, hit_time, hit_fired, hit_first, hit_last}, 32'hFFFFFFFF);
            end else begin
                chk("hit", {hit_chamber, hit_layer, hit_wire, hit_time, hit_fired, hit_first, hit_last}, exp_q.pop_front());
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- test sequence ----------------
    initial begin
        logic [15:0] snap;
        int n;

        // reset state
        #3;
        chk_reset_outputs("rst");
        do_reset();

        // clean event preceded by a filler word
        push_raw(16'h00FF);
        push_event(1);
        wait_idle(400);
        chk("clean_evcnt", event_count, 1);
        chk("clean_eflag", err_flag, 0);
        chk("clean_ecnt", err_count, 0);

        // mis-tagged word in IDLE
        do_reset();
        push_raw({8'h05, 8'hC4});
        wait_idle(100);
        chk("badidle_eflag", err_flag, 1);
        chk("badidle_ecnt", err_count, 1);
        chk("badidle_evcnt", event_count, 0);

        // word 10 replaced by an index-0 tag, then a full tail
        do_reset();
        for (int k = 0; k < 10; k++) begin
            push_word(k, k + 1);
            push_hit(k, k + 1, k == 0, 0);
        end
        push_word(0, 11);
        push_hit(0, 11, 1, 0);
        for (int k = 1; k < 32; k++) begin
            push_word(k, k + 11);
            push_hit(k, k + 11, 0, k == 31);
        end
        wait_idle(400);
        chk("restart_ecnt", err_count, 1);
        chk("restart_evcnt", event_count, 1);

        // partial event aborted by timeout, then a clean event
        do_reset();
        for (int k = 0; k < 5; k++) begin
            push_word(k, k + 1);
            push_hit(k, k + 1, k == 0, 0);
        end
        wait_idle(100);
        cyc(TO + 10);
        chk("timeout_ecnt0", err_count, 1);
        push_event(100);
        wait_idle(400);
        chk("timeout_ecnt", err_count, 1);
        chk("timeout_evcnt", event_count, 1);

        // downstream stall longer than the timeout, mid-event
        do_reset();
        push_event(1);
        n = 0;
        while (nhits < 10 && n < 200) begin cyc(1); n++; end
        chk("stall_reach", 32'(n < 200), 1);
        hit_ready = 1'b0;
        cyc(3);
        chk("stall_vld", hit_valid, 1);
        snap = {hit_chamber, hit_layer, hit_wire, hit_time, hit_fired, hit_first, hit_last};
        for (int i = 0; i < 50; i++) begin
            cyc(1);
            chk("stall_rd_en", fifo_rd_en, 0);
            chk("stall_payload", {hit_valid, hit_chamber, hit_layer, hit_wire, hit_time, hit_fired, hit_first, hit_last}, {1'b1, snap});
        end
        hit_ready = 1'b1;
        wait_idle(400);
        chk("stall_evcnt", event_count, 1);
        chk("stall_ecnt", err_count, 0);

        // err_clear coincident with an error
        do_reset();
        push_raw({8'h07, 8'hC4});
        wait_idle(100);
        chk("clr_pre_ecnt", err_count, 1);
        push_raw({8'h08, 8'hC4});
        n = 0;
        while (!fifo_valid && n < 50) begin cyc(1); n++; end
        chk("clr_reach", 32'(n < 50), 1);
        err_clear = 1'b1;
        cyc(1);
        err_clear = 1'b0;
        cyc(2);
        chk("clr_eflag", err_flag, 0);
        chk("clr_ecnt", err_count, 0);

        // reset pulsed mid-event, then a clean event counts as one
        do_reset();
        push_event(1);
        n = 0;
        while (nhits < 20 && n < 200) begin cyc(1); n++; end
        chk("midrst_reach", 32'(n < 200), 1);
        clr_n = 1'b0;
        #1;
        exp_q.delete();
        chk_reset_outputs("midrst");
        cyc(2);
        clr_n = 1'b1;
        cyc(2);
        push_event(50);
        wait_idle(400);
        chk("midrst_evcnt", event_count, 1);
        chk("midrst_ecnt", err_count, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
